serial_link_data_link_elastic: RTL and testbench
================================================

// Module: serial_link_data_link_elastic
// PURPOSE
//  Next-generation data-link layer of the Serial Link, between the AXI-Stream
//  network side and the per-channel PHY. Serialises a payload into beats over a
//  runtime-selectable subset of channels (degraded-link mode) and reassembles it on RX.
//  Sits where the fixed-width data link sat; credit logic stays upstream.
// PARAMETERS
//  PayloadWidth  64  payload bits per frame
//  NumChannels   4   physical channels
//  ChanWidth     16  bits per channel per beat
//  CntWidth      16  statistics counter width
// PORTS
//  clk_i            in   1                      clock
//  rst_i            in   1                      reset, synchronous, active-high
//  tx_data_i        in   PayloadWidth           frame to send; stable while tx_valid_i=1
//  tx_valid_i       in   1                      frame valid
//  tx_ready_o       out  1                      frame consumed (asserted on last-beat accept)
//  rx_data_o        out  PayloadWidth           reassembled frame
//  rx_valid_o       out  1                      frame valid
//  rx_ready_i       in   1                      downstream ready
//  phy_tx_data_o    out  NumChannels*ChanWidth  beat data, channel i at [i*ChanWidth+:ChanWidth]
//  phy_tx_valid_o   out  NumChannels            per-channel valid
//  phy_tx_ready_i   in   1                      PHY accepts beat
//  phy_rx_data_i    in   NumChannels*ChanWidth  received beat
//  phy_rx_valid_i   in   NumChannels            per-channel valid
//  phy_rx_ready_o   out  NumChannels            per-channel pop
//  cfg_ch_mask_i    in   NumChannels            requested active channels
//  cfg_busy_o       out  1                      mask update pending (frame in flight)
//  cfg_mask_err_o   out  1                      active mask is zero; link disabled
//  stat_clear_i     in   1                      clear counters
//  stat_tx_frames_o out  CntWidth               frames sent
//  stat_rx_frames_o out  CntWidth               frames received
// BEHAVIOUR
//  - Reset: all outputs 0, TX FSM DlTxIdle, RX beat index 0, mask_q='1, counters 0.
//  - A=popcount(mask_q), BW=A*ChanWidth, NB=ceil(PayloadWidth/BW); beat k = payload
//    bits [k*BW+:BW], zero-filled past PayloadWidth; packed onto active channels in
//    ascending index order. Inactive channels: valid 0, data 0, rx ready 0.
//  - TX FSM DlTxIdle: tx_valid_i -> drive beat 0, phy_tx_valid_o=mask_q. On
//    phy_tx_ready_i: NB==1 -> tx_ready_o=1 same cycle, stay; else idx=1, go DlTxSend.
//  - DlTxSend: drive beat idx; on ready idx++; last beat -> tx_ready_o=1, DlTxIdle.
//    Stalled beat holds data and valid unchanged.
//  - RX: beat accepted when all mask_q channels valid and !rx_valid_o;
//    phy_rx_ready_o=mask_q for that cycle; beat written at idx*BW. After beat NB-1:
//    rx_valid_o=1 next cycle, idx=0; held until rx_ready_i. No accept while rx_valid_o=1.
//  - mask_q<=cfg_ch_mask_i only when TX idle, RX idx==0 and !rx_valid_o;
//    cfg_busy_o=1 when mask_q differs from cfg_ch_mask_i but update is blocked.
//  - mask_q==0: cfg_mask_err_o=1, tx_ready_o=0, phy_*_valid/ready=0; no beats.
//  - Reset mid-frame: partial frames dropped, no tx_ready_o pulse.
// CONFIGURATION
//  SERIAL_LINK_DL_STATS_EN defined: saturating counters, +1 per tx_ready_o pulse /
//  per rx_valid_o rise; stat_clear_i wins over simultaneous increment.
//  Undefined: stat_*_o tied 0, no counter flops, stat_clear_i ignored.
// STRUCTURE
//  serial_link_pkg: dl_tx_state_e {DlTxIdle, DlTxSend}, popcount/ceil-div functions.
//  Sub-module serial_link_ch_remap (param Gather: 0 scatter beat onto active channels
//  for TX, 1 gather active channels into a dense beat for RX); two instances.
// TESTING (PayloadWidth=64, NumChannels=4, ChanWidth=16)
//  1 mask 1111, tx 64'h0123_4567_89AB_CDEF, PHY ready -> single beat, tx_ready_o same
//    cycle, phy_tx_data_o equals payload, stat_tx_frames_o=1 (macro on).
//  2 mask 0101 -> beat0 ch0=CDEF ch2=89AB valid=0101; beat1 ch0=4567 ch2=0123;
//    mask 0111 -> NB=2, beat1 ch0=0123, ch1=ch2=0000.
//  3 mask 0001, phy_tx_ready_i toggling 1,0 -> 4 beats, stalled beats unchanged,
//    tx_ready_o only on beat 3.
//  4 RX mask 0011, two beats -> rx_valid_o next cycle with frame; rx_ready_i=0 for 5
//    cycles -> phy_rx_ready_o=0000, third beat waits.
//  5 change mask 1111->0011 mid-frame -> cfg_busy_o=1 until frame done, then new split;
//    mask 0000 -> cfg_mask_err_o=1, tx_ready_o=0.
//  6 rst_i mid-frame -> next cycle idle, outputs 0, mask_q=1111, counters 0.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared types and sizing helpers for the elastic serial-link data-link layer.
package serial_link_pkg;

  typedef enum logic [0:0] {
    DlTxIdle,
    DlTxSend
  } dl_tx_state_e;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

  // A zero divisor means the link is disabled, so zero beats per frame.
  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (b == 0) ? 0 : (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/serial_link_ch_remap.sv
// Maps a dense beat onto the active channels (Gather=0, TX scatter) or packs the
// active channels back into a dense beat (Gather=1, RX gather), ascending channel order.
module serial_link_ch_remap #(
  parameter int NumChannels = 4,
  parameter int ChanWidth   = 16,
  parameter bit Gather      = 1'b0
) (
  input  logic [NumChannels-1:0]           mask,
  input  logic [NumChannels*ChanWidth-1:0] src,
  output logic [NumChannels*ChanWidth-1:0] dst
);

  int rank;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; otherwise a latch is inferred.
    dst  = '0;
    rank = 0;
    for (int i = 0; i < NumChannels; i++) begin
      if (mask[i]) begin
        for (int j = 0; j < NumChannels; j++) begin
          if (rank == j) begin
            if (Gather) dst[j*ChanWidth +: ChanWidth] = src[i*ChanWidth +: ChanWidth];
            else        dst[i*ChanWidth +: ChanWidth] = src[j*ChanWidth +: ChanWidth];
          end
        end
        rank++;
      end
    end
  end

endmodule

// File: rtl/serial_link_data_link_elastic.sv
// Elastic data-link layer: splits frames into beats over a runtime channel subset.
// Optional statistics counters are built when SERIAL_LINK_DL_STATS_EN is defined.
module serial_link_data_link_elastic
  import serial_link_pkg::*;
#(
  parameter int PayloadWidth = 64,
  parameter int NumChannels  = 4,
  parameter int ChanWidth    = 16,
  parameter int CntWidth     = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [PayloadWidth-1:0]          tx_data_i,
  input  logic                             tx_valid_i,
  output logic                             tx_ready_o,
  output logic [PayloadWidth-1:0]          rx_data_o,
  output logic                             rx_valid_o,
  input  logic                             rx_ready_i,
  output logic [NumChannels*ChanWidth-1:0] phy_tx_data_o,
  output logic [NumChannels-1:0]           phy_tx_valid_o,
  input  logic                             phy_tx_ready_i,
  input  logic [NumChannels*ChanWidth-1:0] phy_rx_data_i,
  input  logic [NumChannels-1:0]           phy_rx_valid_i,
  output logic [NumChannels-1:0]           phy_rx_ready_o,
  input  logic [NumChannels-1:0]           cfg_ch_mask_i,
  output logic                             cfg_busy_o,
  output logic                             cfg_mask_err_o,
  input  logic                             stat_clear_i,
  output logic [CntWidth-1:0]              stat_tx_frames_o,
  output logic [CntWidth-1:0]              stat_rx_frames_o
);

  localparam int BeatW    = NumChannels * ChanWidth;
  localparam int WideW    = PayloadWidth + BeatW;
  localparam int MaxBeats = (PayloadWidth + ChanWidth - 1) / ChanWidth;
  localparam int IdxW     = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;

  logic [NumChannels-1:0] mask_q;
  logic                   mask_err;
  logic                   mask_open;
  int unsigned            bw;
  int unsigned            nb;

  always_comb begin
    bw = popcount(32'(mask_q)) * ChanWidth;
    nb = ceil_div(PayloadWidth, bw);
  end

  assign mask_err = (mask_q == '0);

  // ---------------- TX ----------------
  dl_tx_state_e     tx_state, tx_state_d;
  logic [IdxW-1:0]  tx_idx, tx_idx_d, tx_cur;
  logic             tx_active, tx_fire, tx_last;
  logic [WideW-1:0] tx_wide;
  logic [BeatW-1:0] tx_dense, tx_phy;

  always_comb begin
    tx_state_d = tx_state;
    tx_idx_d   = tx_idx;
    tx_cur     = (tx_state == DlTxSend) ? tx_idx : '0;
    tx_active  = !rst_i && !mask_err && ((tx_state == DlTxSend) || tx_valid_i);
    tx_fire    = tx_active && phy_tx_ready_i;
    tx_last    = ((32'(tx_cur) + 32'd1) == nb);
    tx_wide    = WideW'(tx_data_i) >> (32'(tx_cur) * bw);
    tx_dense   = tx_wide[BeatW-1:0];
    tx_ready_o = tx_fire && tx_last;
    if (tx_fire) begin
      if (tx_last) begin
        tx_state_d = DlTxIdle;
        tx_idx_d   = '0;
      end else begin
        tx_state_d = DlTxSend;
        tx_idx_d   = tx_cur + IdxW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state <= DlTxIdle;
      tx_idx   <= '0;
    end else begin
      tx_state <= tx_state_d;
      tx_idx   <= tx_idx_d;
    end
  end

  serial_link_ch_remap #(
    .NumChannels(NumChannels),
    .ChanWidth  (ChanWidth),
    .Gather     (1'b0)
  ) u_tx_scatter (
    .mask(mask_q),
    .src (tx_dense),
    .dst (tx_phy)
  );

  assign phy_tx_valid_o = tx_active ? mask_q : '0;
  assign phy_tx_data_o  = tx_active ? tx_phy : '0;

  // ---------------- RX ----------------
  logic [IdxW-1:0]         rx_idx;
  logic                    rx_valid_q;
  logic [PayloadWidth-1:0] rx_buf;
  logic [BeatW-1:0]        rx_dense;
  logic [WideW-1:0]        rx_wide;
  logic                    rx_accept, rx_last;

  serial_link_ch_remap #(
    .NumChannels(NumChannels),
    .ChanWidth  (ChanWidth),
    .Gather     (1'b1)
  ) u_rx_gather (
    .mask(mask_q),
    .src (phy_rx_data_i),
    .dst (rx_dense)
  );

  always_comb begin
    rx_accept = !rst_i && !mask_err && !rx_valid_q && ((phy_rx_valid_i & mask_q) == mask_q);
    rx_last   = ((32'(rx_idx) + 32'd1) == nb);
    rx_wide   = WideW'(rx_dense) << (32'(rx_idx) * bw);
  end

  // Beat 0 overwrites the buffer, later beats OR into the zeroed upper region.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_idx     <= '0;
      rx_valid_q <= 1'b0;
      // NOTE: the frame buffer is reset too, because rx_data_o must read 0 after reset.
      rx_buf     <= '0;
    end else if (rx_accept) begin
      rx_buf <= (rx_idx == '0) ? rx_wide[PayloadWidth-1:0]
                               : (rx_buf | rx_wide[PayloadWidth-1:0]);
      if (rx_last) begin
        rx_idx     <= '0;
        rx_valid_q <= 1'b1;
      end else begin
        rx_idx <= rx_idx + IdxW'(1);
      end
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign rx_valid_o     = rx_valid_q;
  assign rx_data_o      = rx_buf;
  assign phy_rx_ready_o = rx_accept ? mask_q : '0;

  // ---------------- channel mask ----------------
  assign mask_open = (tx_state == DlTxIdle) && (rx_idx == '0) && !rx_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)          mask_q <= '1;
    else if (mask_open) mask_q <= cfg_ch_mask_i;
  end

  assign cfg_busy_o     = (mask_q != cfg_ch_mask_i) && !mask_open;
  assign cfg_mask_err_o = mask_err;

  // ---------------- statistics ----------------
`ifdef SERIAL_LINK_DL_STATS_EN
  logic [CntWidth-1:0] tx_cnt, rx_cnt;

  // Clear takes priority over a coincident increment; counters saturate.
  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clear_i) begin
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_ready_o && (tx_cnt != '1))           tx_cnt <= tx_cnt + CntWidth'(1);
      if (rx_accept && rx_last && (rx_cnt != '1)) rx_cnt <= rx_cnt + CntWidth'(1);
    end
  end

  assign stat_tx_frames_o = tx_cnt;
  assign stat_rx_frames_o = rx_cnt;
`else
  logic stat_unused;
  assign stat_unused      = stat_clear_i;
  assign stat_tx_frames_o = '0;
  assign stat_rx_frames_o = '0;
`endif

endmodule

// File: tb/tb_serial_link_data_link_elastic.sv
// Directed plus randomized bench for serial_link_data_link_elastic with a
// frame-level reference model; expects stats only when SERIAL_LINK_DL_STATS_EN is set.
module tb_serial_link_data_link_elastic;

`ifdef SERIAL_LINK_DL_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic        clk_i, rst_i;
  logic [63:0] tx_data_i;
  logic        tx_valid_i, tx_ready_o;
  logic [63:0] rx_data_o;
  logic        rx_valid_o, rx_ready_i;
  logic [63:0] phy_tx_data_o;
  logic [3:0]  phy_tx_valid_o;
  logic        phy_tx_ready_i;
  logic [63:0] phy_rx_data_i;
  logic [3:0]  phy_rx_valid_i, phy_rx_ready_o;
  logic [3:0]  cfg_ch_mask_i;
  logic        cfg_busy_o, cfg_mask_err_o, stat_clear_i;
  logic [15:0] stat_tx_frames_o, stat_rx_frames_o;

  int errors = 0;
  int checks = 0;
  int tx_cnt_m = 0;
  int rx_cnt_m = 0;

  serial_link_data_link_elastic dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .tx_data_i       (tx_data_i),
    .tx_valid_i      (tx_valid_i),
    .tx_ready_o      (tx_ready_o),
    .rx_data_o       (rx_data_o),
    .rx_valid_o      (rx_valid_o),
    .rx_ready_i      (rx_ready_i),
    .phy_tx_data_o   (phy_tx_data_o),
    .phy_tx_valid_o  (phy_tx_valid_o),
    .phy_tx_ready_i  (phy_tx_ready_i),
    .phy_rx_data_i   (phy_rx_data_i),
    .phy_rx_valid_i  (phy_rx_valid_i),
    .phy_rx_ready_o  (phy_rx_ready_o),
    .cfg_ch_mask_i   (cfg_ch_mask_i),
    .cfg_busy_o      (cfg_busy_o),
    .cfg_mask_err_o  (cfg_mask_err_o),
    .stat_clear_i    (stat_clear_i),
    .stat_tx_frames_o(stat_tx_frames_o),
    .stat_rx_frames_o(stat_rx_frames_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: frame -> beats, from the channel-split rules ----
  function automatic int model_active(input logic [3:0] m);
    int a;
    a = 0;
    for (int c = 0; c < 4; c++) if (m[c]) a++;
    return a;
  endfunction

  function automatic int model_nb(input logic [3:0] m);
    int bw;
    bw = model_active(m) * 16;
    return (bw == 0) ? 0 : (64 + bw - 1) / bw;
  endfunction

  function automatic logic [63:0] model_beat(input logic [63:0] p, input logic [3:0] m, input int k);
    logic [127:0] w;
    logic [63:0]  b;
    int bw, j;
    bw = model_active(m) * 16;
    b  = '0;
    j  = 0;
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        w = {64'd0, p} >> (k * bw + j * 16);
        b[c*16 +: 16] = w[15:0];
        j++;
      end
    end
    return b;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [3:0] m);
    logic [63:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) if (m[c]) r[c*16 +: 16] = 16'hFFFF;
    return r;
  endfunction

  function automatic logic [63:0] exp_stat(input int n);
    return StatsOn ? 64'(n) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_mask(input logic [3:0] m);
    cfg_ch_mask_i = m;
    tick();
  endtask

  // Sends one frame; mask m must already be the active mask.
  task automatic tx_frame(input logic [63:0] p, input logic [3:0] m, input bit toggle);
    int nb, k, cyc;
    bit rdy;
    nb  = model_nb(m);
    k   = 0;
    cyc = 0;
    tx_data_i  = p;
    tx_valid_i = 1'b1;
    while (k < nb && cyc < 64) begin
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      phy_tx_ready_i = rdy;
      #1;
      check("tx_beat",  phy_tx_data_o, model_beat(p, m, k));
      check("tx_valid", 64'(phy_tx_valid_o), 64'(m));
      check("tx_ready", 64'(tx_ready_o), 64'(rdy && (k == nb - 1)));
      tick();
      if (rdy) k++;
      cyc++;
    end
    check("tx_done", 64'(k), 64'(nb));
    tx_cnt_m++;
    tx_valid_i     = 1'b0;
    phy_tx_ready_i = 1'b0;
    #1;
    check("stat_tx", 64'(stat_tx_frames_o), exp_stat(tx_cnt_m));
  endtask

  task automatic rx_beat(input logic [63:0] p, input logic [3:0] m, input int k, input logic [3:0] exp_pop);
    phy_rx_data_i  = model_beat(p, m, k) | ({$urandom, $urandom} & ~lane_mask(m));
    phy_rx_valid_i = m | (4'($urandom) & ~m);
    #1;
    check("rx_pop", 64'(phy_rx_ready_o), 64'(exp_pop));
    tick();
  endtask

  task automatic rx_frame(input logic [63:0] p, input logic [3:0] m);
    for (int k = 0; k < model_nb(m); k++) rx_beat(p, m, k, m);
    phy_rx_valid_i = '0;
    #1;
    rx_cnt_m++;
    check("rx_valid", 64'(rx_valid_o), 64'd1);
    check("rx_data",  rx_data_o, p);
    check("stat_rx",  64'(stat_rx_frames_o), exp_stat(rx_cnt_m));
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    check("rx_drain", 64'(rx_valid_o), 64'd0);
  endtask

  initial begin
    logic [63:0] p, p2;
    logic [3:0]  m;
    rst_i = 1'b1; tx_data_i = '0; tx_valid_i = 1'b0; rx_ready_i = 1'b0;
    phy_tx_ready_i = 1'b0; phy_rx_data_i = '0; phy_rx_valid_i = '0;
    cfg_ch_mask_i = 4'hF; stat_clear_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    check("rst_tx_ready",  64'(tx_ready_o), 64'd0);
    check("rst_phy_valid", 64'(phy_tx_valid_o), 64'd0);
    check("rst_phy_data",  phy_tx_data_o, 64'd0);
    check("rst_rx_valid",  64'(rx_valid_o), 64'd0);
    check("rst_rx_data",   rx_data_o, 64'd0);
    check("rst_rx_pop",    64'(phy_rx_ready_o), 64'd0);
    check("rst_err",       64'(cfg_mask_err_o), 64'd0);
    check("rst_busy",      64'(cfg_busy_o), 64'd0);
    check("rst_stat_tx",   64'(stat_tx_frames_o), 64'd0);
    check("rst_stat_rx",   64'(stat_rx_frames_o), 64'd0);

    // Full-width link: one beat, payload appears verbatim
    tx_frame(64'h0123_4567_89AB_CDEF, 4'b1111, 1'b0);

    // Two channels, then three channels with zero fill on the last beat
    set_mask(4'b0101);
    tx_frame(64'h0123_4567_89AB_CDEF, 4'b0101, 1'b0);
    set_mask(4'b0111);
    tx_frame(64'h0123_4567_89AB_CDEF, 4'b0111, 1'b0);

    // Single channel with a stalling PHY
    set_mask(4'b0001);
    tx_frame(64'hDEAD_BEEF_CAFE_F00D, 4'b0001, 1'b1);

    // RX back-pressure: completed frame blocks the next beat
    set_mask(4'b0011);
    p  = {$urandom, $urandom};
    p2 = {$urandom, $urandom};
    rx_beat(p, 4'b0011, 0, 4'b0011);
    rx_beat(p, 4'b0011, 1, 4'b0011);
    rx_cnt_m++;
    phy_rx_data_i  = model_beat(p2, 4'b0011, 0);
    phy_rx_valid_i = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rx_hold_pop",   64'(phy_rx_ready_o), 64'd0);
      check("rx_hold_valid", 64'(rx_valid_o), 64'd1);
      check("rx_hold_data",  rx_data_o, p);
      tick();
    end
    rx_ready_i = 1'b1;
    #1;
    check("rx_consume_pop", 64'(phy_rx_ready_o), 64'd0);
    tick();
    rx_ready_i = 1'b0;
    check("rx_resume_pop",   64'(phy_rx_ready_o), 64'b0011);
    check("rx_resume_valid", 64'(rx_valid_o), 64'd0);
    tick();
    rx_beat(p2, 4'b0011, 1, 4'b0011);
    phy_rx_valid_i = '0;
    #1;
    rx_cnt_m++;
    check("rx2_valid", 64'(rx_valid_o), 64'd1);
    check("rx2_data",  rx_data_o, p2);
    check("stat_rx2",  64'(stat_rx_frames_o), exp_stat(rx_cnt_m));
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;

    // Mask change while a received frame is held
    set_mask(4'b1111);
    p = {$urandom, $urandom};
    rx_beat(p, 4'b1111, 0, 4'b1111);
    phy_rx_valid_i = '0;
    rx_cnt_m++;
    cfg_ch_mask_i = 4'b0011;
    #1;
    check("busy_set", 64'(cfg_busy_o), 64'd1);
    tx_frame(p, 4'b1111, 1'b0);
    check("busy_hold",  64'(cfg_busy_o), 64'd1);
    check("held_frame", rx_data_o, p);
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    check("busy_clear", 64'(cfg_busy_o), 64'd0);
    tick();
    tx_frame(64'h1111_2222_3333_4444, 4'b0011, 1'b0);

    // Disabled link
    set_mask(4'b0000);
    tx_valid_i = 1'b1; tx_data_i = 64'hFFFF_0000_FFFF_0000;
    phy_tx_ready_i = 1'b1; phy_rx_valid_i = 4'hF;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("err_flag",      64'(cfg_mask_err_o), 64'd1);
      check("err_tx_ready",  64'(tx_ready_o), 64'd0);
      check("err_phy_valid", 64'(phy_tx_valid_o), 64'd0);
      check("err_phy_data",  phy_tx_data_o, 64'd0);
      check("err_rx_pop",    64'(phy_rx_ready_o), 64'd0);
      tick();
    end
    tx_valid_i = 1'b0; phy_tx_ready_i = 1'b0; phy_rx_valid_i = '0;
    set_mask(4'b1111);
    check("err_gone", 64'(cfg_mask_err_o), 64'd0);

    // Counter clear
    stat_clear_i = 1'b1;
    tick();
    stat_clear_i = 1'b0;
    tx_cnt_m = 0;
    rx_cnt_m = 0;
    check("clr_stat_tx", 64'(stat_tx_frames_o), 64'd0);
    check("clr_stat_rx", 64'(stat_rx_frames_o), 64'd0);

    // Randomized frames over random nonzero masks
    for (int n = 0; n < 12; n++) begin
      m = 4'($urandom_range(1, 15));
      set_mask(m);
      tx_frame({$urandom, $urandom}, m, 1'($urandom));
      rx_frame({$urandom, $urandom}, m);
    end

    // Reset in the middle of TX and RX frames
    set_mask(4'b0001);
    p = {$urandom, $urandom};
    tx_data_i = p; tx_valid_i = 1'b1; phy_tx_ready_i = 1'b1;
    tick(); tick();
    rx_beat(p, 4'b0001, 0, 4'b0001);
    rst_i = 1'b1;
    #1;
    check("rst_mid_tx_ready", 64'(tx_ready_o), 64'd0);
    tick();
    rst_i = 1'b0; tx_valid_i = 1'b0; phy_tx_ready_i = 1'b0; phy_rx_valid_i = '0;
    tx_cnt_m = 0;
    rx_cnt_m = 0;
    #1;
    check("rst2_tx_ready",  64'(tx_ready_o), 64'd0);
    check("rst2_phy_valid", 64'(phy_tx_valid_o), 64'd0);
    check("rst2_rx_valid",  64'(rx_valid_o), 64'd0);
    check("rst2_stat_tx",   64'(stat_tx_frames_o), 64'd0);
    check("rst2_stat_rx",   64'(stat_rx_frames_o), 64'd0);
    tx_valid_i = 1'b1;
    #1;
    check("rst2_mask_full", 64'(phy_tx_valid_o), 64'hF);
    check("rst2_beat",      phy_tx_data_o, p);
    tx_valid_i = 1'b0;
    tick();
    tx_frame({$urandom, $urandom}, 4'b0001, 1'b0);
    rx_frame({$urandom, $urandom}, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
